// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory access stage: access sizes, response
// error codes and the access FSM states.
package mips_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = WORD_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10,
        RESP   = 2'b11
    } state_e;

    // Accesses that cannot be served by a single aligned word transaction.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return |off;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// Picks the addressed byte/half lane out of a read word and sign- or
// zero-extends it to a full register value.
module mem_lane_ext
    import mips_mem_pkg::*;
(
    input  logic [WORD_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  size_e             size,
    input  logic              zext,
    output logic [WORD_W-1:0] ext
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (offset)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: ext = {{24{lane_b[7] & ~zext}}, lane_b};
            SZ_HALF: ext = {{16{lane_h[15] & ~zext}}, lane_h};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns one EX/MEM load/store into a word-aligned
// valid/ready memory transaction and returns a single-cycle response.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [LANES-1:0]  mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    output logic              busy
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e            state;
    logic [CNT_W-1:0]  tmo_cnt;
    size_e             lat_size;
    logic [1:0]        lat_off;
    logic              lat_zext;
    logic              lat_write;
    size_e             req_sz;
    logic [WORD_W-1:0] load_ext;
    logic              timeout_hit;

    function automatic logic [LANES-1:0] lane_enables(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return LANES'(1) << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return '1;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] lane_replicate(input size_e sz, input logic [WORD_W-1:0] d);
        case (sz)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign req_sz    = size_e'(req_size);
    assign req_ready = (state == IDLE);

    // The counter saturates at its last value, so once the budget is spent
    // any further REQ/WAIT_R cycle without a completing event aborts.
    assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt == CNT_LAST);

    mem_lane_ext u_lane_ext (
        .rdata  (mem_rdata),
        .offset (lat_off),
        .size   (lat_size),
        .zext   (lat_zext),
        .ext    (load_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            lat_size   <= SZ_BYTE;
            lat_off    <= '0;
            lat_zext   <= 1'b0;
            lat_write  <= 1'b0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_NONE;
            busy       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_size  <= req_sz;
                        lat_off   <= req_addr[1:0];
                        lat_zext  <= req_unsigned;
                        lat_write <= req_write;
                        tmo_cnt   <= '0;
                        busy      <= 1'b1;
                        if (is_misaligned(req_sz, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= ERR_ALIGN;
                        end else begin
                            state     <= REQ;
                            mem_valid <= 1'b1;
                            mem_we    <= req_write;
                            mem_be    <= lane_enables(req_sz, req_addr[1:0]);
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= lane_replicate(req_sz, req_wdata);
                        end
                    end
                end

                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (lat_write) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= ERR_NONE;
                        end else begin
                            state <= WAIT_R;
                        end
                    end else if (timeout_hit) begin
                        mem_valid  <= 1'b0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= ERR_TIMEOUT;
                    end
                    if (tmo_cnt != CNT_LAST) tmo_cnt <= tmo_cnt + CNT_W'(1);
                end

                WAIT_R: begin
                    if (mem_rvalid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_ext;
                        resp_err   <= ERR_NONE;
                    end else if (timeout_hit) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= ERR_TIMEOUT;
                    end
                    if (tmo_cnt != CNT_LAST) tmo_cnt <= tmo_cnt + CNT_W'(1);
                end

                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit, checked against a
// transaction-level model of latency, byte enables and load extension.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        resp_valid, busy;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          d;      // cycles of mem_valid before mem_ready is given
        int          r;      // idle cycles after the handshake before mem_rvalid
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        int          resp_k;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic        mv_at_resp;
        int          vcnt;
        int          first_k;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stable;
        logic        entry_ready;
        logic        entry_resp;
        logic [31:0] entry_rdata;
        logic [1:0]  entry_err;
    } obs_t;

    typedef struct {
        int          k;
        logic [1:0]  err;
        logic [31:0] rdata;
        int          vcnt;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    function automatic txn_t mk(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input int d, input int r, input logic [31:0] rd);
        txn_t t;
        t.write = w; t.size = sz; t.uns = u; t.addr = a; t.wdata = wd;
        t.d = d; t.r = r; t.rdata = rd;
        return t;
    endfunction

    // Expected outcome measured in cycles after the accept edge.
    function automatic exp_t model(input txn_t t);
        exp_t   e;
        int     off, nbytes;
        logic   mis;
        longint v;
        off    = int'(t.addr[1:0]);
        nbytes = (t.size == 2'b00) ? 1 : (t.size == 2'b01) ? 2 : 4;
        mis    = (t.size == 2'b11) || ((off % nbytes) != 0);
        e.addr = t.addr & 32'hFFFF_FFFC;
        e.be   = 4'(((1 << nbytes) - 1) << off);
        e.wdata = (nbytes == 1) ? t.wdata[7:0] * 32'h0101_0101 :
                  (nbytes == 2) ? t.wdata[15:0] * 32'h0001_0001 : t.wdata;
        v = longint'(t.rdata) >> (8 * off);
        v = v % (longint'(1) << (8 * nbytes));
        if (!t.uns && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
            v = v - (longint'(1) << (8 * nbytes));
        e.rdata = 32'h0;
        e.err   = 2'b00;
        if (mis) begin
            e.k = 1; e.err = 2'b01; e.vcnt = 0;
        end else if (t.d + 1 > TO) begin
            e.k = TO + 1; e.err = 2'b10; e.vcnt = TO;
        end else if (t.write) begin
            e.k = t.d + 2; e.vcnt = t.d + 1;
        end else if (t.d + t.r + 2 > TO) begin
            e.k = TO + 1; e.err = 2'b10; e.vcnt = t.d + 1;
        end else begin
            e.k = t.d + t.r + 3; e.vcnt = t.d + 1; e.rdata = 32'(v);
        end
        return e;
    endfunction

    // Issues one request, plays the memory side, and returns at the negedge
    // of the cycle where the response is first seen.
    task automatic run_txn(input txn_t t, output obs_t o);
        int   vcnt, wcnt;
        logic hs;
        vcnt = 0; wcnt = 0; hs = 1'b0;
        o.resp_k = -1; o.err = 2'b00; o.rdata = 32'h0; o.mv_at_resp = 1'b0;
        o.first_k = -1; o.we = 1'b0; o.be = 4'h0; o.addr = 32'h0; o.wdata = 32'h0;
        o.stable = 1'b1;
        @(negedge clk);
        o.entry_ready = req_ready;
        o.entry_resp  = resp_valid;
        o.entry_rdata = resp_rdata;
        o.entry_err   = resp_err;
        req_valid = 1'b1; req_write = t.write; req_size = t.size;
        req_unsigned = t.uns; req_addr = t.addr; req_wdata = t.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rvalid = 1'b0;
            if (resp_valid) begin
                o.resp_k = k; o.err = resp_err; o.rdata = resp_rdata; o.mv_at_resp = mem_valid;
                break;
            end
            if (mem_valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    o.first_k = k; o.we = mem_we; o.be = mem_be; o.addr = mem_addr; o.wdata = mem_wdata;
                end else if ({mem_we, mem_be, mem_addr, mem_wdata} !== {o.we, o.be, o.addr, o.wdata}) begin
                    o.stable = 1'b0;
                end
                mem_ready  = (vcnt > t.d);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                hs = mem_ready;
            end else if (hs && !t.write) begin
                wcnt++;
                if (wcnt == t.r + 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = t.rdata;
                end
            end
        end
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        o.vcnt = vcnt;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready, busy, mem_valid, resp_valid, mem_we} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, busy, mem_valid, resp_valid, mem_we});
        end
        tests_run++;
        if ({mem_be, mem_addr, mem_wdata} !== 68'h0) begin
            tests_failed++;
            $display("FAIL reset_mem: got be=%h addr=%h wdata=%h expected zeros", mem_be, mem_addr, mem_wdata);
        end
        tests_run++;
        if ({resp_rdata, resp_err} !== 34'h0) begin
            tests_failed++;
            $display("FAIL reset_resp: got rdata=%h err=%b expected zeros", resp_rdata, resp_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_byte;
        obs_t o;
        run_txn(mk(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, 0, 0, 32'h0), o);
        tests_run++;
        if (o.first_k !== 1) begin tests_failed++; $display("FAIL sb_mem_valid_cycle: got %0d expected 1", o.first_k); end
        tests_run++;
        if (o.be !== 4'b1000) begin tests_failed++; $display("FAIL sb_be: got %b expected 1000", o.be); end
        tests_run++;
        if (o.addr !== 32'h100) begin tests_failed++; $display("FAIL sb_addr: got %h expected 00000100", o.addr); end
        tests_run++;
        if (o.wdata !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", o.wdata); end
        tests_run++;
        if (o.we !== 1'b1) begin tests_failed++; $display("FAIL sb_we: got %b expected 1", o.we); end
        tests_run++;
        if (o.resp_k !== 2) begin tests_failed++; $display("FAIL sb_latency: got %0d expected 2", o.resp_k); end
        tests_run++;
        if ({o.err, o.rdata} !== 34'h0) begin tests_failed++; $display("FAIL sb_resp: got err=%b rdata=%h expected 00/0", o.err, o.rdata); end
    endtask

    task automatic test_load_half;
        obs_t o;
        run_txn(mk(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 0, 2, 32'h8001_1234), o);
        tests_run++;
        if (o.resp_k !== 5) begin tests_failed++; $display("FAIL lh_latency: got %0d expected 5", o.resp_k); end
        tests_run++;
        if (o.rdata !== 32'hFFFF_8001) begin tests_failed++; $display("FAIL lh_rdata: got %h expected ffff8001", o.rdata); end
        tests_run++;
        if (o.err !== 2'b00) begin tests_failed++; $display("FAIL lh_err: got %b expected 00", o.err); end
        tests_run++;
        if ({o.we, o.be, o.addr} !== {1'b0, 4'b1100, 32'h200}) begin
            tests_failed++; $display("FAIL lh_mem: got we=%b be=%b addr=%h expected 0/1100/00000200", o.we, o.be, o.addr);
        end
        run_txn(mk(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 0, 2, 32'h8001_1234), o);
        tests_run++;
        if (o.entry_resp !== 1'b0) begin tests_failed++; $display("FAIL resp_one_cycle: got %b expected 0", o.entry_resp); end
        tests_run++;
        if (o.rdata !== 32'h0000_8001) begin tests_failed++; $display("FAIL lhu_rdata: got %h expected 00008001", o.rdata); end
    endtask

    task automatic test_reset_wait_r;
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h80; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        tests_run++;
        if ({busy, mem_valid} !== 2'b10) begin tests_failed++; $display("FAIL wait_r_state: got busy/mv=%b expected 10", {busy, mem_valid}); end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({req_ready, busy, mem_valid, resp_valid} !== 4'b1000) begin
            tests_failed++; $display("FAIL async_reset_ctrl: got %b expected 1000", {req_ready, busy, mem_valid, resp_valid});
        end
        tests_run++;
        if ({mem_addr, mem_be, resp_rdata, resp_err} !== 70'h0) begin
            tests_failed++; $display("FAIL async_reset_data: got addr=%h be=%b rdata=%h err=%b expected zeros", mem_addr, mem_be, resp_rdata, resp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (resp_valid || busy) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL late_rvalid_ignored: got activity=%b expected 0", seen); end
    endtask

    task automatic test_misaligned;
        obs_t o;
        run_txn(mk(1'b0, 2'b10, 1'b0, 32'h006, 32'h0, 0, 0, 32'h1234_5678), o);
        tests_run++;
        if (o.vcnt !== 0) begin tests_failed++; $display("FAIL lw_mis_no_mem: got %0d mem_valid cycles expected 0", o.vcnt); end
        tests_run++;
        if ({o.resp_k, o.err, o.rdata} !== {32'd1, 2'b01, 32'h0}) begin
            tests_failed++; $display("FAIL lw_mis_resp: got k=%0d err=%b rdata=%h expected 1/01/0", o.resp_k, o.err, o.rdata);
        end
        run_txn(mk(1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFF_FFFF, 0, 0, 32'h0), o);
        tests_run++;
        if ({o.vcnt, o.resp_k, o.err} !== {32'd0, 32'd1, 2'b01}) begin
            tests_failed++; $display("FAIL rsvd_size: got vcnt=%0d k=%0d err=%b expected 0/1/01", o.vcnt, o.resp_k, o.err);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({resp_valid, resp_err} !== 3'b001) begin
            tests_failed++; $display("FAIL err_hold: got valid/err=%b expected 001", {resp_valid, resp_err});
        end
    endtask

    task automatic test_timeout;
        obs_t        o;
        logic [31:0] rd;
        run_txn(mk(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 99, 0, 32'h0), o);
        tests_run++;
        if (o.vcnt !== TO) begin tests_failed++; $display("FAIL to_req_cycles: got %0d expected %0d", o.vcnt, TO); end
        tests_run++;
        if ({o.resp_k, o.err, o.mv_at_resp} !== {32'(TO + 1), 2'b10, 1'b0}) begin
            tests_failed++; $display("FAIL to_resp: got k=%0d err=%b mv=%b expected %0d/10/0", o.resp_k, o.err, o.mv_at_resp, TO + 1);
        end
        rd = $urandom;
        run_txn(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0, rd), o);
        tests_run++;
        if (o.entry_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %b expected 1", o.entry_ready); end
        tests_run++;
        if ({o.resp_k, o.err, o.rdata, o.addr} !== {32'd3, 2'b00, rd, 32'h10}) begin
            tests_failed++; $display("FAIL b2b_lw: got k=%0d err=%b rdata=%h addr=%h expected 3/00/%h/00000010", o.resp_k, o.err, o.rdata, o.addr, rd);
        end
        run_txn(mk(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 0, 5, 32'h0), o);
        tests_run++;
        if ({o.resp_k, o.err} !== {32'(TO + 1), 2'b10}) begin
            tests_failed++; $display("FAIL to_wait_r: got k=%0d err=%b expected %0d/10", o.resp_k, o.err, TO + 1);
        end
    endtask

    task automatic test_coincide;
        obs_t        o;
        logic [31:0] rd;
        rd = $urandom;
        run_txn(mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 1, rd), o);
        tests_run++;
        if ({o.resp_k, o.err, o.rdata} !== {32'(TO + 1), 2'b00, rd}) begin
            tests_failed++; $display("FAIL coincide_rvalid_wins: got k=%0d err=%b rdata=%h expected %0d/00/%h", o.resp_k, o.err, o.rdata, TO + 1, rd);
        end
        run_txn(mk(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_BEEF, TO - 1, 0, 32'h0), o);
        tests_run++;
        if ({o.resp_k, o.err, o.wdata, o.be} !== {32'(TO + 1), 2'b00, 32'hBEEF_BEEF, 4'b1100}) begin
            tests_failed++; $display("FAIL coincide_ready_wins: got k=%0d err=%b wdata=%h be=%b expected %0d/00/beefbeef/1100", o.resp_k, o.err, o.wdata, o.be, TO + 1);
        end
    endtask

    task automatic test_random;
        txn_t        t;
        obs_t        o;
        exp_t        e;
        logic [31:0] prev_rdata;
        logic [1:0]  prev_err;
        for (int i = 0; i < 60; i++) begin
            t.write = 1'($urandom_range(0, 1));
            t.size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            t.uns   = 1'($urandom_range(0, 1));
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.rdata = $urandom;
            if (t.write) begin
                t.d = $urandom_range(0, 5);
                t.r = 0;
            end else begin
                t.d = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(0, TO - 2);
                t.r = $urandom_range(0, 3);
            end
            e = model(t);
            run_txn(t, o);
            tests_run++;
            if ({o.entry_ready, o.entry_resp} !== 2'b10) begin
                tests_failed++; $display("FAIL rnd%0d_entry: got ready/resp=%b expected 10", i, {o.entry_ready, o.entry_resp});
            end
            if (i > 0) begin
                tests_run++;
                if ({o.entry_rdata, o.entry_err} !== {prev_rdata, prev_err}) begin
                    tests_failed++; $display("FAIL rnd%0d_hold: got %h/%b expected %h/%b", i, o.entry_rdata, o.entry_err, prev_rdata, prev_err);
                end
            end
            tests_run++;
            if ({o.resp_k, o.err, o.rdata} !== {32'(e.k), e.err, e.rdata}) begin
                tests_failed++; $display("FAIL rnd%0d_resp: got k=%0d err=%b rdata=%h expected %0d/%b/%h (w=%b sz=%b a=%h d=%0d r=%0d)",
                                         i, o.resp_k, o.err, o.rdata, e.k, e.err, e.rdata, t.write, t.size, t.addr, t.d, t.r);
            end
            tests_run++;
            if (o.vcnt !== e.vcnt) begin
                tests_failed++; $display("FAIL rnd%0d_mem_cycles: got %0d expected %0d", i, o.vcnt, e.vcnt);
            end
            if (e.vcnt > 0) begin
                tests_run++;
                if ({o.first_k, o.stable, o.we, o.be, o.addr} !== {32'd1, 1'b1, t.write, e.be, e.addr}) begin
                    tests_failed++; $display("FAIL rnd%0d_mem_req: got k=%0d stable=%b we=%b be=%b addr=%h expected 1/1/%b/%b/%h",
                                             i, o.first_k, o.stable, o.we, o.be, o.addr, t.write, e.be, e.addr);
                end
                if (t.write) begin
                    tests_run++;
                    if (o.wdata !== e.wdata) begin
                        tests_failed++; $display("FAIL rnd%0d_wdata: got %h expected %h", i, o.wdata, e.wdata);
                    end
                end
            end
            prev_rdata = e.rdata;
            prev_err   = e.err;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_store_byte();
        test_load_half();
        test_reset_wait_r();
        test_misaligned();
        test_timeout();
        test_coincide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage of the MIPS core; the write/narrowing end of the datapath, complementing the sign-extension read path.
- Accepts one load/store (LB/LBU/LH/LHU/LW/SB/SH/SW) from the EX/MEM boundary and generates word-aligned memory transactions with byte enables.
- Drives a valid/ready memory port with variable read latency.
- Returns sign- or zero-extended load data, or an error code, as a single-cycle response.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT_R before abort; 0 disables timeout
ADDR_W, 32, address width (memory address is word-aligned, bits [1:0] forced to 0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit idle, can accept request
req_write  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  load zero-extends when 1
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data (right-justified)
mem_valid  output  1  memory request valid
mem_ready  input  1  memory accepts request
mem_we  output  1  write enable
mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
mem_addr  output  ADDR_W  word-aligned address
mem_wdata  output  32  lane-replicated store data
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores/errors
resp_err  output  2  00 ok, 01 misaligned/reserved size, 10 timeout
busy  output  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; mem_valid, mem_we, resp_valid, busy=0; mem_be, mem_addr, mem_wdata, resp_rdata, resp_err=0; timeout counter=0.
- A reset mid-transaction abandons it; mem_valid drops without waiting for ready.
- All outputs are registered except req_ready, which equals (state==IDLE).
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE: on req_valid, latch the request.
  - Half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> RESP with err=01. No memory transaction.
  - Otherwise -> REQ.
- REQ: mem_valid=1; mem_addr, mem_be, mem_we, mem_wdata held stable until mem_ready.
  - On mem_ready: store -> RESP; load -> WAIT_R.
- WAIT_R: mem_valid=0. On mem_rvalid, capture the lane-extracted result -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: addr[1]? 1100 : 0011
  - word: 1111
- Store data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
- Load extract: lane chosen by addr[1:0]. Sign-extend from bit 7 (byte) or bit 15 (half) unless req_unsigned; word loads pass through.
- Latency (accept edge = T):
  - mem_valid high in cycle T+1.
  - Store with immediate mem_ready: resp_valid at T+2.
  - Load with mem_rvalid the cycle after acceptance: resp_valid at T+3.
  - Misaligned request: resp_valid at T+1.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT_R.
  - When it reaches TIMEOUT with no completing event -> RESP, err=10, mem_valid drops.
  - If mem_rvalid/mem_ready and timeout coincide, the completing event wins.
- mem_rvalid is ignored outside WAIT_R, and is not sampled in the same cycle as the mem_ready handshake.
- resp_rdata and resp_err hold their values until the next RESP.
- A new request may be accepted in the cycle after RESP (IDLE).

Decomposition:
- Package mips_mem_pkg holds: size enum (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD), error enum (ERR_NONE/ERR_ALIGN/ERR_TIMEOUT), and the FSM state enum.
- Combinational sub-module mem_lane_ext handles lane select and sign/zero extension of read data.
- Byte-enable/replication logic stays inline.

Test Plan:
- SB addr=0x103, wdata=0x000000A5, mem_ready immediate -> mem_be=1000, mem_addr=0x100, mem_wdata=0xA5A5A5A5, resp_valid at T+2, err=00.
- LH addr=0x202, mem_rdata=0x8001_1234 on rvalid 3 cycles later -> resp_rdata=0xFFFF8001; LHU same stimulus -> 0x00008001.
- LW addr=0x006 -> no mem_valid ever, resp_valid at T+1, err=01; req_size=11 gives the same result.
- Load with mem_ready held low and TIMEOUT=4 -> resp_err=10 after 4 cycles in REQ, mem_valid deasserts, then back-to-back LW 0x10 completes normally.
- Assert rst while in WAIT_R -> outputs zero immediately, state IDLE, a late mem_rvalid is ignored and no resp_valid occurs.
- In WAIT_R, mem_rvalid arrives in the same cycle the timeout expires -> err=00, data returned.
